// File: rtl/vga_cursor_overlay.sv
// rtl/vga_cursor_overlay.sv - pixel-clock stage overlaying a 2bpp hardware cursor on the RGB stream
module vga_cursor_overlay #(
    parameter int CUR_SIZE_LOG2 = 5
) (
    input  logic                       clk_pclk_i,
    input  logic                       rst_nreset_i,
    input  logic                       ctrl_ven,
    input  logic                       cur_en_i,
    input  logic [15:0]                cur_x_i,
    input  logic [15:0]                cur_y_i,
    input  logic [23:0]                cur_col0_i,
    input  logic [23:0]                cur_col1_i,
    input  logic                       de_i,
    input  logic                       vs_i,
    input  logic                       hsync_i,
    input  logic                       vsync_i,
    input  logic                       csync_i,
    input  logic                       blank_i,
    input  logic [23:0]                rgb_i,
    output logic [2*CUR_SIZE_LOG2-1:0] cur_adr_o,
    input  logic [1:0]                 cur_q_i,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic                       csync_o,
    output logic                       blank_o,
    output logic [23:0]                rgb_o
);

    logic [1:0]  ven_s;
    logic [1:0]  en_s;
    logic [15:0] cx_s1, cx_s2;
    logic [15:0] cy_s1, cy_s2;

    logic        en_w;
    logic [15:0] cx_w, cy_w;
    logic        vs_d, de_d;
    logic [15:0] x, y;

    logic [16:0] dx_f, dy_f;
    logic        hit_c;

    logic        hit0, de0;
    logic [23:0] rgb0;
    logic [3:0]  sync0;
    logic [23:0] pix;

    // Cursor regs cross from the bus domain; working copies only move on a frame boundary.
    always_ff @(posedge clk_pclk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            ven_s <= '0;
            en_s  <= '0;
            cx_s1 <= '0;
            cx_s2 <= '0;
            cy_s1 <= '0;
            cy_s2 <= '0;
            en_w  <= 1'b0;
            cx_w  <= '0;
            cy_w  <= '0;
            vs_d  <= 1'b0;
            de_d  <= 1'b0;
        end else begin
            ven_s <= {ven_s[0], ctrl_ven};
            en_s  <= {en_s[0], cur_en_i};
            cx_s1 <= cur_x_i;
            cx_s2 <= cx_s1;
            cy_s1 <= cur_y_i;
            cy_s2 <= cy_s1;
            vs_d  <= vs_i;
            de_d  <= de_i;
            if (vs_i && !vs_d) begin
                en_w <= en_s[1];
                cx_w <= cx_s2;
                cy_w <= cy_s2;
            end
        end
    end

    // x holds the column of the pixel currently on de_i, y the active line index.
    always_ff @(posedge clk_pclk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            x <= '0;
            y <= '0;
        end else if (!ven_s[1] || vs_i) begin
            x <= '0;
            y <= '0;
        end else if (de_d && !de_i) begin
            x <= '0;
            if (y != 16'hFFFF) begin
                y <= y + 16'd1;
            end
        end else if (de_i && x != 16'hFFFF) begin
            x <= x + 16'd1;
        end
    end

    always_comb begin
        dx_f  = {1'b0, x} - {1'b0, cx_w};
        dy_f  = {1'b0, y} - {1'b0, cy_w};
        hit_c = en_w && ven_s[1] && de_i
                && !dx_f[16] && !dy_f[16]
                && (dx_f[15:CUR_SIZE_LOG2] == '0)
                && (dy_f[15:CUR_SIZE_LOG2] == '0);
    end

    always_ff @(posedge clk_pclk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            hit0      <= 1'b0;
            de0       <= 1'b0;
            rgb0      <= '0;
            sync0     <= '0;
            cur_adr_o <= '0;
        end else begin
            hit0      <= hit_c;
            de0       <= de_i;
            rgb0      <= rgb_i;
            sync0     <= {hsync_i, vsync_i, csync_i, blank_i};
            cur_adr_o <= {dy_f[CUR_SIZE_LOG2-1:0], dx_f[CUR_SIZE_LOG2-1:0]};
        end
    end

    // The RAM answers within the cycle after the address register, so its data feeds the output mux directly.
    always_comb begin
        pix = rgb0;
        if (hit0 && de0) begin
            case (cur_q_i)
                2'b01:   pix = ~rgb0;
                2'b10:   pix = cur_col0_i;
                2'b11:   pix = cur_col1_i;
                default: pix = rgb0;
            endcase
        end
    end

    always_ff @(posedge clk_pclk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            rgb_o   <= '0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            csync_o <= 1'b0;
            blank_o <= 1'b0;
        end else begin
            rgb_o   <= pix;
            hsync_o <= sync0[3];
            vsync_o <= sync0[2];
            csync_o <= sync0[1];
            blank_o <= sync0[0];
        end
    end

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// tb/tb_vga_cursor_overlay.sv - scoreboard bench for vga_cursor_overlay
module tb_vga_cursor_overlay;

    logic        clk_pclk_i = 1'b0;
    logic        rst_nreset_i;
    logic        ctrl_ven, cur_en_i;
    logic [15:0] cur_x_i, cur_y_i;
    logic [23:0] cur_col0_i, cur_col1_i;
    logic        de_i, vs_i, hsync_i, vsync_i, csync_i, blank_i;
    logic [23:0] rgb_i;
    logic [9:0]  cur_adr_o;
    logic [1:0]  cur_q_i;
    logic        hsync_o, vsync_o, csync_o, blank_o;
    logic [23:0] rgb_o;

    always #5 clk_pclk_i = ~clk_pclk_i;

    logic [1:0] mem [0:1023];
    assign cur_q_i = mem[cur_adr_o];

    vga_cursor_overlay #(.CUR_SIZE_LOG2(5)) dut (
        .clk_pclk_i(clk_pclk_i), .rst_nreset_i(rst_nreset_i),
        .ctrl_ven(ctrl_ven), .cur_en_i(cur_en_i), .cur_x_i(cur_x_i), .cur_y_i(cur_y_i),
        .cur_col0_i(cur_col0_i), .cur_col1_i(cur_col1_i),
        .de_i(de_i), .vs_i(vs_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .csync_i(csync_i), .blank_i(blank_i), .rgb_i(rgb_i),
        .cur_adr_o(cur_adr_o), .cur_q_i(cur_q_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .csync_o(csync_o), .blank_o(blank_o),
        .rgb_o(rgb_o)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic [3:0]  sy;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic       exp_en = 1'b0;
    int         exp_cx = 0;
    int         exp_cy = 0;
    logic       last_vs = 1'b0;
    logic [9:0] adr_log [0:639];

    function automatic logic [23:0] model(input logic de, input int col, input int line,
                                          input logic [23:0] rgb);
        int dx, dy;
        model = rgb;
        dx = col - exp_cx;
        dy = line - exp_cy;
        if (de && ctrl_ven && exp_en && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
            case (mem[dy * 32 + dx])
                2'b01:   model = ~rgb;
                2'b10:   model = cur_col0_i;
                2'b11:   model = cur_col1_i;
                default: model = rgb;
            endcase
        end
    endfunction

    function automatic logic [23:0] pick(input bit rnd, input logic [23:0] fix);
        pick = rnd ? 24'($urandom) : fix;
    endfunction

    // One pixel clock: drive inputs, push expectation, compare the entry that is now due.
    task automatic cycle(input logic de, input logic vs, input logic [23:0] rgb,
                         input int col, input int line);
        exp_t e, want;
        logic [3:0] sy;
        @(negedge clk_pclk_i);
        sy = 4'($urandom);
        {hsync_i, vsync_i, csync_i, blank_i} = sy;
        de_i  = de;
        vs_i  = vs;
        rgb_i = rgb;
        if (vs && !last_vs) begin
            exp_en = cur_en_i;
            exp_cx = int'(cur_x_i);
            exp_cy = int'(cur_y_i);
        end
        last_vs = vs;
        e.rgb = model(de, col, line, rgb);
        e.sy  = sy;
        sb.push_back(e);
        @(posedge clk_pclk_i);
        #1;
        if (de && line == 0 && col >= 0 && col < 640) adr_log[col] = cur_adr_o;
        if (sb.size() >= 2) begin
            want = sb.pop_front();
            n_chk++;
            if ({rgb_o, hsync_o, vsync_o, csync_o, blank_o} !== {want.rgb, want.sy}) begin
                n_fail++;
                $display("FAIL pixel_out t=%0t got rgb=%h sy=%b expected rgb=%h sy=%b",
                         $time, rgb_o, {hsync_o, vsync_o, csync_o, blank_o}, want.rgb, want.sy);
            end
        end
    endtask

    task automatic frame(input int w, input int h, input bit rnd, input logic [23:0] fix,
                         input int chg_line, input int chg_x);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, pick(1'b1, 24'h0), 0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, pick(1'b1, 24'h0), 0, 0);
        for (int l = 0; l < h; l++) begin
            if (l == chg_line) cur_x_i = 16'(chg_x);
            for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, pick(1'b1, 24'h0), 0, l);
            for (int c = 0; c < w; c++) cycle(1'b1, 1'b0, pick(rnd, fix), c, l);
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, pick(1'b1, 24'h0), 0, 0);
    endtask

    task automatic fill_mem(input logic [1:0] code);
        for (int i = 0; i < 1024; i++) mem[i] = code;
    endtask

    task automatic check_zero_outputs(input string tag);
        n_chk++;
        if (rgb_o !== 24'h0) begin
            n_fail++;
            $display("FAIL %s_rgb got %h expected 000000", tag, rgb_o);
        end
        n_chk++;
        if ({hsync_o, vsync_o, csync_o, blank_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL %s_sync got %b expected 0000", tag, {hsync_o, vsync_o, csync_o, blank_o});
        end
        n_chk++;
        if (cur_adr_o !== 10'h0) begin
            n_fail++;
            $display("FAIL %s_adr got %h expected 000", tag, cur_adr_o);
        end
    endtask

    task automatic test_reset();
        rst_nreset_i = 1'b0;
        repeat (3) @(posedge clk_pclk_i);
        #1;
        check_zero_outputs("reset");
        @(negedge clk_pclk_i);
        rst_nreset_i = 1'b1;
    endtask

    task automatic test_passthrough();
        ctrl_ven = 1'b1;
        cur_en_i = 1'b0;
        frame(48, 3, 1'b0, 24'h123456, -1, 0);
    endtask

    task automatic test_cursor_fill();
        fill_mem(2'b10);
        cur_col0_i = 24'hFF0000;
        cur_col1_i = 24'h00FF00;
        cur_en_i = 1'b1;
        cur_x_i = 16'd10;
        cur_y_i = 16'd2;
        frame(48, 4, 1'b1, 24'h0, -1, 0);
    endtask

    task automatic test_invert();
        fill_mem(2'b00);
        mem[0] = 2'b01;
        frame(48, 4, 1'b0, 24'h0F0F0F, -1, 0);
    endtask

    task automatic test_mid_frame_move();
        fill_mem(2'b10);
        frame(48, 4, 1'b1, 24'h0, 1, 14);
        frame(48, 4, 1'b1, 24'h0, -1, 0);
    endtask

    task automatic test_clip();
        fill_mem(2'b11);
        cur_x_i = 16'd630;
        cur_y_i = 16'd0;
        frame(640, 2, 1'b1, 24'h0, -1, 0);
        n_chk++;
        if (adr_log[630] !== 10'd0) begin
            n_fail++;
            $display("FAIL clip_adr_first got %h expected 000", adr_log[630]);
        end
        n_chk++;
        if (adr_log[635] !== 10'd5) begin
            n_fail++;
            $display("FAIL clip_adr_mid got %h expected 005", adr_log[635]);
        end
        n_chk++;
        if (adr_log[639] !== 10'd9) begin
            n_fail++;
            $display("FAIL clip_adr_last got %h expected 009", adr_log[639]);
        end
    endtask

    task automatic test_disable();
        fill_mem(2'b11);
        cur_x_i = 16'd10;
        cur_y_i = 16'd2;
        cur_en_i = 1'b1;
        ctrl_ven = 1'b0;
        frame(48, 4, 1'b1, 24'h0, -1, 0);
        ctrl_ven = 1'b1;
        cur_en_i = 1'b0;
        frame(48, 4, 1'b1, 24'h0, -1, 0);
    endtask

    task automatic test_reset_midline();
        cur_en_i = 1'b1;
        cur_x_i = 16'd5;
        cur_y_i = 16'd0;
        frame(48, 2, 1'b1, 24'h0, -1, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, pick(1'b1, 24'h0), 0, 2);
        for (int c = 0; c < 10; c++) cycle(1'b1, 1'b0, pick(1'b1, 24'h0), c, 2);
        rst_nreset_i = 1'b0;
        #1;
        check_zero_outputs("midline_reset");
        de_i = 1'b0;
        vs_i = 1'b0;
        repeat (2) @(posedge clk_pclk_i);
        @(negedge clk_pclk_i);
        rst_nreset_i = 1'b1;
        sb.delete();
        exp_en = 1'b0;
        exp_cx = 0;
        exp_cy = 0;
        last_vs = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, pick(1'b1, 24'h0), 0, 0);
        for (int c = 0; c < 48; c++) cycle(1'b1, 1'b0, pick(1'b1, 24'h0), c, 0);
        frame(48, 2, 1'b1, 24'h0, -1, 0);
    endtask

    initial begin
        rst_nreset_i = 1'b0;
        ctrl_ven = 1'b0;
        cur_en_i = 1'b0;
        cur_x_i = 16'd0;
        cur_y_i = 16'd0;
        cur_col0_i = 24'h0;
        cur_col1_i = 24'h0;
        de_i = 1'b0;
        vs_i = 1'b0;
        {hsync_i, vsync_i, csync_i, blank_i} = 4'b0;
        rgb_i = 24'h0;
        fill_mem(2'b00);
        for (int i = 0; i < 640; i++) adr_log[i] = 10'h0;

        test_reset();
        test_passthrough();
        test_cursor_fill();
        test_invert();
        test_mid_frame_move();
        test_clip();
        test_disable();
        test_reset_midline();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
